// File: rtl/display_pkg.sv
// Shared definitions for the framebuffer double-buffer controller:
// address field widths, controller state encoding and the default {row, col} address type.
package display_pkg;

    // Width of the row field for a given number of display rows.
    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Width of the column field for a given number of pixels per row.
    function automatic int col_width(input int columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

    // Full pixel address width: {row, col}.
    function automatic int addr_width(input int rows, input int columns);
        return row_width(rows) + col_width(columns);
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        CLEAR   = 2'd2
    } fb_state_e;

    localparam int DEF_ROWS    = 8;
    localparam int DEF_COLUMNS = 32;
    localparam int DEF_RW      = row_width(DEF_ROWS);
    localparam int DEF_CW      = col_width(DEF_COLUMNS);

    // Pixel address for the default panel size; row is the upper field.
    typedef struct packed {
        logic [DEF_RW-1:0] row;
        logic [DEF_CW-1:0] col;
    } fb_addr_t;

endpackage

// File: rtl/fb_sweep_counter.sv
// Nested row/column address counter used to sweep a whole bank one pixel per cycle.
// start_i rewinds to {0,0}; step_i advances col first, then row; last_o flags the final pixel.
module fb_sweep_counter
    import display_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int COLUMNS = 32,
    localparam int RW     = row_width(ROWS),
    localparam int CW     = col_width(COLUMNS),
    localparam int AW     = RW + CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLUMNS - 1);

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    // Row/column counter: rewind on start, otherwise advance one pixel per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (start_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (step_i) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign addr_o = {row_q, col_q};
    assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffer controller between the renderer and the display driver.
// Renderer writes go to the back bank; a commit waits for the driver's safe_flip pulse,
// swaps banks, acknowledges, and optionally zero-fills the new back bank before reopening writes.
//
// Write handshake: a write transfers on a cycle where wr_valid && wr_ready are both high;
// wr_ready depends only on state (high in IDLE), never on wr_valid. Out-of-range addresses
// still transfer but produce no BRAM write.
module framebuffer_swap_ctrl
    import display_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLUMNS    = 32,
    parameter int BITDEPTH   = 8,
    parameter bit AUTO_CLEAR = 1'b1,
    localparam int RW        = row_width(ROWS),
    localparam int CW        = col_width(COLUMNS),
    localparam int AW        = RW + CW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                safe_flip,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [AW-1:0]       wr_addr,
    input  logic [BITDEPTH-1:0] wr_data,
    input  logic                commit_req,
    output logic                commit_ack,
    output logic                front_sel,
    output logic                fb_we,
    output logic                fb_bank,
    output logic [AW-1:0]       fb_waddr,
    output logic [BITDEPTH-1:0] fb_wdata,
    output logic                busy,
    output logic [15:0]         flip_count,
    output fb_state_e           state_dbg
);

    localparam int RW1 = RW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [RW:0] ROWS_LIM = RW1'(ROWS);
    localparam logic [CW:0] COLS_LIM = CW1'(COLUMNS);

    fb_state_e             state_q;
    logic                  front_q;
    logic                  ack_q;
    logic                  we_q;
    logic                  bank_q;
    logic [AW-1:0]         waddr_q;
    logic [BITDEPTH-1:0]   wdata_q;
    logic [15:0]           count_q;

    logic                  in_range;
    logic                  sweep_start;
    logic                  sweep_step;
    logic [AW-1:0]         sweep_addr;
    logic                  sweep_last;

    assign in_range = ({1'b0, wr_addr[AW-1:CW]} < ROWS_LIM) &&
                      ({1'b0, wr_addr[CW-1:0]}  < COLS_LIM);

    // The sweep rewinds at the flip edge so the first CLEAR cycle targets {0,0}.
    assign sweep_start = (state_q == PENDING) && safe_flip;
    assign sweep_step  = (state_q == CLEAR);

    fb_sweep_counter #(
        .ROWS    (ROWS),
        .COLUMNS (COLUMNS)
    ) u_sweep (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sweep_start),
        .step_i  (sweep_step),
        .addr_o  (sweep_addr),
        .last_o  (sweep_last)
    );

    // Controller FSM with registered BRAM write port, ack pulse, bank select and flip counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            ack_q   <= 1'b0;
            we_q    <= 1'b0;
            bank_q  <= 1'b1;
            waddr_q <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            ack_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_valid && in_range) begin
                        we_q    <= 1'b1;
                        bank_q  <= ~front_q;
                        waddr_q <= wr_addr;
                        wdata_q <= wr_data;
                    end
                    // A write in the commit cycle is still part of the committed frame.
                    if (commit_req) begin
                        state_q <= PENDING;
                    end
                end
                PENDING: begin
                    if (safe_flip) begin
                        front_q <= ~front_q;
                        ack_q   <= 1'b1;
                        count_q <= count_q + 16'd1;
                        state_q <= AUTO_CLEAR ? CLEAR : IDLE;
                    end
                end
                CLEAR: begin
                    // front_q already points at the new front, so ~front_q is the new back bank.
                    we_q    <= 1'b1;
                    bank_q  <= ~front_q;
                    waddr_q <= sweep_addr;
                    wdata_q <= '0;
                    if (sweep_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign commit_ack = ack_q;
    assign front_sel  = front_q;
    assign fb_we      = we_q;
    assign fb_bank    = bank_q;
    assign fb_waddr   = waddr_q;
    assign fb_wdata   = wdata_q;
    assign flip_count = count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Bench for framebuffer_swap_ctrl: two instances share clock, reset, flip pulse and write bus.
//   inst a: 8x32, AUTO_CLEAR=1      inst b: 8x24, AUTO_CLEAR=0
// A per-instance transaction-level reference model predicts every registered output.
module tb_framebuffer_swap_ctrl;
    import display_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          safe_flip = 1'b0;
    logic          wr_valid  = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic          commit_req [2];

    logic          wr_ready   [2];
    logic          commit_ack [2];
    logic          front_sel  [2];
    logic          fb_we      [2];
    logic          fb_bank    [2];
    logic [AW-1:0] fb_waddr   [2];
    logic [DW-1:0] fb_wdata   [2];
    logic          busy       [2];
    logic [15:0]   flip_count [2];
    fb_state_e     state_dbg  [2];

    framebuffer_swap_ctrl #(
        .ROWS(8), .COLUMNS(32), .BITDEPTH(DW), .AUTO_CLEAR(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .safe_flip(safe_flip),
        .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req[0]), .commit_ack(commit_ack[0]), .front_sel(front_sel[0]),
        .fb_we(fb_we[0]), .fb_bank(fb_bank[0]), .fb_waddr(fb_waddr[0]), .fb_wdata(fb_wdata[0]),
        .busy(busy[0]), .flip_count(flip_count[0]), .state_dbg(state_dbg[0])
    );

    framebuffer_swap_ctrl #(
        .ROWS(8), .COLUMNS(24), .BITDEPTH(DW), .AUTO_CLEAR(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .safe_flip(safe_flip),
        .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_req(commit_req[1]), .commit_ack(commit_ack[1]), .front_sel(front_sel[1]),
        .fb_we(fb_we[1]), .fb_bank(fb_bank[1]), .fb_waddr(fb_waddr[1]), .fb_wdata(fb_wdata[1]),
        .busy(busy[1]), .flip_count(flip_count[1]), .state_dbg(state_dbg[1])
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = accepting writes, 1 = waiting for flip window, 2 = clearing back bank
    int p_cols [2] = '{32, 24};
    bit p_ac   [2] = '{1'b1, 1'b0};
    string p_nm [2] = '{"a", "b"};

    int m_mode [2];
    bit m_front[2];
    int m_idx  [2];
    bit e_we   [2];
    bit e_bank [2];
    bit e_ack  [2];
    int e_waddr[2];
    int e_wdata[2];
    int e_count[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;  m_front[i] = 1'b0; m_idx[i] = 0;
            e_we[i] = 1'b0; e_bank[i] = 1'b1;  e_ack[i] = 1'b0;
            e_waddr[i] = 0; e_wdata[i] = 0;    e_count[i] = 0;
        end
    endtask

    // Predict the outputs after the next clock edge from the inputs currently driven.
    task automatic model_step(input int i);
        int row, col, cols;
        cols     = p_cols[i];
        e_ack[i] = 1'b0;
        e_we[i]  = 1'b0;
        case (m_mode[i])
            0: begin
                if (wr_valid) begin
                    row = int'(wr_addr) / 32;
                    col = int'(wr_addr) % 32;
                    if (row < 8 && col < cols) begin
                        e_we[i] = 1'b1; e_bank[i] = !m_front[i];
                        e_waddr[i] = int'(wr_addr); e_wdata[i] = int'(wr_data);
                    end
                end
                if (commit_req[i]) m_mode[i] = 1;
            end
            1: begin
                if (safe_flip) begin
                    m_front[i] = !m_front[i];
                    e_ack[i]   = 1'b1;
                    e_count[i] = (e_count[i] + 1) % 65536;
                    m_mode[i]  = p_ac[i] ? 2 : 0;
                    m_idx[i]   = 0;
                end
            end
            default: begin
                e_we[i] = 1'b1; e_bank[i] = !m_front[i]; e_wdata[i] = 0;
                e_waddr[i] = (m_idx[i] / cols) * 32 + (m_idx[i] % cols);
                m_idx[i]++;
                if (m_idx[i] == 8 * cols) m_mode[i] = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            check({p_nm[i], "_ready"}, 32'(wr_ready[i]),   32'(m_mode[i] == 0));
            check({p_nm[i], "_busy"},  32'(busy[i]),       32'(m_mode[i] != 0));
            check({p_nm[i], "_ack"},   32'(commit_ack[i]), 32'(e_ack[i]));
            check({p_nm[i], "_front"}, 32'(front_sel[i]),  32'(m_front[i]));
            check({p_nm[i], "_count"}, 32'(flip_count[i]), 32'(e_count[i]));
            check({p_nm[i], "_we"},    32'(fb_we[i]),      32'(e_we[i]));
            if (e_we[i]) begin
                check({p_nm[i], "_bank"},  32'(fb_bank[i]),  32'(e_bank[i]));
                check({p_nm[i], "_waddr"}, 32'(fb_waddr[i]), 32'(e_waddr[i]));
                check({p_nm[i], "_wdata"}, 32'(fb_wdata[i]), 32'(e_wdata[i]));
            end
        end
    endtask

    // ---------------- driver ----------------
    // One clock: predict, clock, compare #1 after the edge; renderer drops commit_req on ack.
    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs();
        for (int i = 0; i < 2; i++) begin
            if (e_ack[i]) commit_req[i] = 1'b0;
        end
    endtask

    task automatic finish_report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog time limit reached");
        finish_report();
    end

    // ---------------- stimulus ----------------
    initial begin
        fb_addr_t a_35;
        fb_addr_t a_oor;
        fb_addr_t a_27;
        int       n;

        commit_req[0] = 1'b0;
        commit_req[1] = 1'b0;
        model_reset();

        // Reset values
        #12;
        for (int i = 0; i < 2; i++) begin
            check({p_nm[i], "_rst_front"}, 32'(front_sel[i]),  32'd0);
            check({p_nm[i], "_rst_ack"},   32'(commit_ack[i]), 32'd0);
            check({p_nm[i], "_rst_we"},    32'(fb_we[i]),      32'd0);
            check({p_nm[i], "_rst_bank"},  32'(fb_bank[i]),    32'd1);
            check({p_nm[i], "_rst_waddr"}, 32'(fb_waddr[i]),   32'd0);
            check({p_nm[i], "_rst_wdata"}, 32'(fb_wdata[i]),   32'd0);
            check({p_nm[i], "_rst_count"}, 32'(flip_count[i]), 32'd0);
            check({p_nm[i], "_rst_ready"}, 32'(wr_ready[i]),   32'd1);
            check({p_nm[i], "_rst_busy"},  32'(busy[i]),       32'd0);
            check({p_nm[i], "_rst_state"}, 32'(state_dbg[i]),  32'(IDLE));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write {3,5} = 0xA7 lands in bank 1 one cycle later
        a_35.row = 3'd3;
        a_35.col = 5'd5;
        wr_valid = 1'b1; wr_addr = a_35; wr_data = 8'hA7;
        tick();
        wr_valid = 1'b0;
        check("t1_we",    32'(fb_we[0]),    32'd1);
        check("t1_bank",  32'(fb_bank[0]),  32'd1);
        check("t1_waddr", 32'(fb_waddr[0]), 32'h65);
        check("t1_wdata", 32'(fb_wdata[0]), 32'hA7);

        // Column 30 is beyond 24 columns on b, valid on a
        a_oor.row = 3'd0;
        a_oor.col = 5'd30;
        wr_valid = 1'b1; wr_addr = a_oor; wr_data = 8'h55;
        tick();
        wr_valid = 1'b0;
        check("oor_b_we", 32'(fb_we[1]), 32'd0);
        check("oor_a_we", 32'(fb_we[0]), 32'd1);

        // Commit on b, flip 10 cycles later; a sees the flip pulse without a commit
        commit_req[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t2_b_ready_pending", 32'(wr_ready[1]), 32'd0);
        end
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        check("t2_b_front",  32'(front_sel[1]),  32'd1);
        check("t2_b_ack",    32'(commit_ack[1]), 32'd1);
        check("t2_b_count",  32'(flip_count[1]), 32'd1);
        check("t4_a_nocommit_front", 32'(front_sel[0]), 32'd0);
        tick();
        check("t2_b_ack_pulse", 32'(commit_ack[1]), 32'd0);
        check("t2_b_ready",     32'(wr_ready[1]),   32'd1);

        // Commit on a with auto-clear: 256 zero writes to bank 0
        commit_req[0] = 1'b1;
        tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        check("t3_a_front", 32'(front_sel[0]), 32'd1);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (!fb_we[0]) break;
            check("t3_clr_bank",  32'(fb_bank[0]),  32'd0);
            check("t3_clr_addr",  32'(fb_waddr[0]), 32'(n % 256));
            check("t3_clr_data",  32'(fb_wdata[0]), 32'd0);
            n++;
        end
        check("t3_clr_count", 32'(n), 32'd256);
        check("t3_ready",     32'(wr_ready[0]), 32'd1);

        // safe_flip in the commit cycle does not flip; the next pulse does
        commit_req[0] = 1'b1;
        safe_flip     = 1'b1;
        tick();
        safe_flip = 1'b0;
        check("t4_noflip_front", 32'(front_sel[0]), 32'd1);
        check("t4_busy",         32'(busy[0]),      32'd1);
        repeat (3) tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        check("t4_flip_front", 32'(front_sel[0]), 32'd0);
        n = 0;
        while (!wr_ready[0] && n < 300) begin
            tick();
            n++;
        end
        check("t4_clear_done", 32'(wr_ready[0]), 32'd1);

        // Write and commit in the same cycle on b: write goes to the back bank (0)
        a_27.row = 3'd2;
        a_27.col = 5'd7;
        wr_valid = 1'b1; wr_addr = a_27; wr_data = 8'h3C; commit_req[1] = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("t6_b_we",   32'(fb_we[1]),    32'd1);
        check("t6_b_bank", 32'(fb_bank[1]),  32'd0);
        check("t6_b_busy", 32'(busy[1]),     32'd1);
        repeat (2) tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        check("t6_b_front", 32'(front_sel[1]), 32'd0);

        // Reset in the middle of a clear sweep on a
        commit_req[0] = 1'b1;
        tick();
        safe_flip = 1'b1;
        tick();
        safe_flip = 1'b0;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (fb_we[0] && fb_waddr[0] == 8'd100) begin
                n = 1;
                break;
            end
        end
        check("t5_reached_100", 32'(n), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_front", 32'(front_sel[0]),  32'd0);
        check("t5_we",    32'(fb_we[0]),      32'd0);
        check("t5_state", 32'(state_dbg[0]),  32'(IDLE));
        check("t5_count", 32'(flip_count[0]), 32'd0);
        commit_req[0] = 1'b0;
        commit_req[1] = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("t5_we_held", 32'(fb_we[0]), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        check("t5_no_more_clear", 32'(fb_we[0]), 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            wr_valid  = ($urandom_range(0, 3) != 0);
            wr_addr   = AW'($urandom_range(0, 255));
            wr_data   = DW'($urandom_range(0, 255));
            safe_flip = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!commit_req[i] && $urandom_range(0, 29) == 0) commit_req[i] = 1'b1;
            end
            tick();
        end
        wr_valid  = 1'b0;
        safe_flip = 1'b0;

        finish_report();
    end

endmodule
